// File: rtl/reg_file_16x32_pkg.sv
// Shared register-file constants and types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// DATA_W     register width
// NREGS      number of architectural registers
// REG_ADDR_W register address width
// PC_IDX     index of the program-counter register (R15)
package reg_file_16x32_pkg;

  localparam int DATA_W     = 32;
  localparam int NREGS      = 16;
  localparam int REG_ADDR_W = $clog2(NREGS);
  localparam int PC_IDX     = 15;

  // PC_IDX sized to the address bus, so address compares need no width casts.
  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_IDX);

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : reg_file_16x32_pkg

// File: rtl/reg_file_16x32_rd_port.sv
// One combinational read port of the register array.
// Latency: zero (pure mux from the stored array, no write bypass).
// Backpressure: none; the output is always valid.
//
// Ports:
//   regs  in   NREGS x word_t   current register array contents
//   addr  in   REG_ADDR_W       register to read
//   dat   out  word_t           regs[addr]
module reg_file_16x32_rd_port
  import reg_file_16x32_pkg::*;
(
  input  word_t     regs [NREGS],
  input  reg_addr_t addr,
  output word_t     dat
);

  assign dat = regs[addr];

endmodule : reg_file_16x32_rd_port

// File: rtl/reg_file_16x32.sv
// 16 x 32-bit ARM-style register file; R15 is the program counter.
// Latency: reads are combinational; writes land on the rising clk edge.
// Backpressure: none; one write and four reads are accepted every cycle.
//
// Ports:
//   clk                          in   1    rising-edge clock
//   rst_n                        in   1    asynchronous active-low reset, clears all registers
//   IR_addr_Rn/Rs/Rm             in   4    read addresses for the ALU/shifter operand ports
//   mux_addr_Rd_or_15            in   4    write address, also the Rd (store data) read address
//   CNTRL_write_en_addr_Rd       in   1    write enable for mux_addr_Rd_or_15
//   pc_next                      in   32   loaded into R15 every cycle unless R15 is written
//   mux_ALU_result_or_DMEM_data  in   32   write data
//   Rn/Rs/Rm/Rd                  out  32   register contents at the matching address
//   pc_out                       out  32   current contents of R15
module reg_file_16x32
  import reg_file_16x32_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t IR_addr_Rn,
  input  reg_addr_t IR_addr_Rs,
  input  reg_addr_t IR_addr_Rm,
  input  reg_addr_t mux_addr_Rd_or_15,
  input  logic      CNTRL_write_en_addr_Rd,
  input  word_t     pc_next,
  input  word_t     mux_ALU_result_or_DMEM_data,
  output word_t     Rn,
  output word_t     Rs,
  output word_t     Rm,
  output word_t     Rd,
  output word_t     pc_out
);

  word_t regs [NREGS];

  logic wr_gpr;
  logic wr_pc;

  // An explicit write to R15 takes priority over the free-running PC update.
  assign wr_pc  = CNTRL_write_en_addr_Rd && (mux_addr_Rd_or_15 == PC_ADDR);
  assign wr_gpr = CNTRL_write_en_addr_Rd && (mux_addr_Rd_or_15 != PC_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_gpr) begin
        regs[mux_addr_Rd_or_15] <= mux_ALU_result_or_DMEM_data;
      end
      regs[PC_IDX] <= wr_pc ? mux_ALU_result_or_DMEM_data : pc_next;
    end
  end

  reg_file_16x32_rd_port u_rd_rn (.regs(regs), .addr(IR_addr_Rn),        .dat(Rn));
  reg_file_16x32_rd_port u_rd_rs (.regs(regs), .addr(IR_addr_Rs),        .dat(Rs));
  reg_file_16x32_rd_port u_rd_rm (.regs(regs), .addr(IR_addr_Rm),        .dat(Rm));
  reg_file_16x32_rd_port u_rd_rd (.regs(regs), .addr(mux_addr_Rd_or_15), .dat(Rd));

  assign pc_out = regs[PC_IDX];

endmodule : reg_file_16x32

// File: tb/tb_reg_file_16x32.sv
// Self-checking bench for reg_file_16x32: directed scenarios plus randomized
// traffic compared against an array model of the architectural registers.
module tb_reg_file_16x32;

  logic        clk;
  logic        rst_n;
  logic [3:0]  IR_addr_Rn;
  logic [3:0]  IR_addr_Rs;
  logic [3:0]  IR_addr_Rm;
  logic [3:0]  mux_addr_Rd_or_15;
  logic        CNTRL_write_en_addr_Rd;
  logic [31:0] pc_next;
  logic [31:0] mux_ALU_result_or_DMEM_data;
  logic [31:0] Rn;
  logic [31:0] Rs;
  logic [31:0] Rm;
  logic [31:0] Rd;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  // Architectural state as seen by software: 16 words, R15 = PC.
  logic [31:0] mdl [16];

  reg_file_16x32 dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .IR_addr_Rn                  (IR_addr_Rn),
    .IR_addr_Rs                  (IR_addr_Rs),
    .IR_addr_Rm                  (IR_addr_Rm),
    .mux_addr_Rd_or_15           (mux_addr_Rd_or_15),
    .CNTRL_write_en_addr_Rd      (CNTRL_write_en_addr_Rd),
    .pc_next                     (pc_next),
    .mux_ALU_result_or_DMEM_data (mux_ALU_result_or_DMEM_data),
    .Rn                          (Rn),
    .Rs                          (Rs),
    .Rm                          (Rm),
    .Rd                          (Rd),
    .pc_out                      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge, apply the architectural write rules to the model,
  // then step just past the edge so outputs can be sampled.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    end else if (CNTRL_write_en_addr_Rd && mux_addr_Rd_or_15 == 4'd15) begin
      mdl[15] = mux_ALU_result_or_DMEM_data;
    end else begin
      if (CNTRL_write_en_addr_Rd) mdl[mux_addr_Rd_or_15] = mux_ALU_result_or_DMEM_data;
      mdl[15] = pc_next;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    CNTRL_write_en_addr_Rd = 1'b1;
    mux_addr_Rd_or_15 = 4'd3;
    mux_ALU_result_or_DMEM_data = 32'h1234_5678;
    pc_next = 32'h40;
    IR_addr_Rn = 4'd3; IR_addr_Rs = 4'd15; IR_addr_Rm = 4'd0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    #2;
    // Edges during reset must not disturb the cleared registers.
    repeat (2) @(posedge clk);
    #1;
    checks++; if (Rn !== 32'd0) begin errors++; $display("FAIL reset_rn: got %h want 0", Rn); end
    checks++; if (Rs !== 32'd0) begin errors++; $display("FAIL reset_rs: got %h want 0", Rs); end
    checks++; if (Rm !== 32'd0) begin errors++; $display("FAIL reset_rm: got %h want 0", Rm); end
    checks++; if (Rd !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h want 0", Rd); end
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_out); end
    @(negedge clk);
    rst_n = 1'b1;
    CNTRL_write_en_addr_Rd = 1'b0;
  endtask

  task automatic test_directed();
    // 1: enable low, PC advances only.
    CNTRL_write_en_addr_Rd = 1'b0; pc_next = 32'd4;
    IR_addr_Rn = 4'd0; IR_addr_Rs = 4'd1; IR_addr_Rm = 4'd2;
    tick();
    checks++; if (pc_out !== 32'd4) begin errors++; $display("FAIL dir_pc4: got %h want 4", pc_out); end
    checks++; if ({Rn, Rs, Rm} !== 96'd0) begin errors++; $display("FAIL dir_gpr0: got %h %h %h want 0", Rn, Rs, Rm); end
    // 2: write R0 = 177.
    CNTRL_write_en_addr_Rd = 1'b1; mux_addr_Rd_or_15 = 4'd0;
    mux_ALU_result_or_DMEM_data = 32'd177; pc_next = 32'd8;
    tick();
    checks++; if (Rn !== 32'd177) begin errors++; $display("FAIL dir_r0_rn: got %0d want 177", Rn); end
    checks++; if (Rd !== 32'd177) begin errors++; $display("FAIL dir_r0_rd: got %0d want 177", Rd); end
    // 3: R1 = 255, R2 = 127, then read all three.
    mux_addr_Rd_or_15 = 4'd1; mux_ALU_result_or_DMEM_data = 32'd255; pc_next = 32'd12;
    tick();
    mux_addr_Rd_or_15 = 4'd2; mux_ALU_result_or_DMEM_data = 32'd127; pc_next = 32'd16;
    tick();
    checks++; if ({Rn, Rs, Rm} !== {32'd177, 32'd255, 32'd127}) begin
      errors++; $display("FAIL dir_three_ports: got %0d %0d %0d want 177 255 127", Rn, Rs, Rm);
    end
    // 4: enable low leaves R1 alone, PC still loads.
    CNTRL_write_en_addr_Rd = 1'b0; mux_addr_Rd_or_15 = 4'd1;
    mux_ALU_result_or_DMEM_data = 32'hDEAD_BEEF; pc_next = 32'd8;
    tick();
    checks++; if (Rd !== 32'd255) begin errors++; $display("FAIL dir_en_low_r1: got %h want 255", Rd); end
    checks++; if (pc_out !== 32'd8) begin errors++; $display("FAIL dir_en_low_pc: got %h want 8", pc_out); end
    // 5: explicit R15 write beats pc_next, then PC resumes from pc_next.
    CNTRL_write_en_addr_Rd = 1'b1; mux_addr_Rd_or_15 = 4'd15;
    mux_ALU_result_or_DMEM_data = 32'h100; pc_next = 32'h0C;
    tick();
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL dir_pc_write_wins: got %h want 100", pc_out); end
    checks++; if (Rd !== 32'h100) begin errors++; $display("FAIL dir_rd_reads_pc: got %h want 100", Rd); end
    CNTRL_write_en_addr_Rd = 1'b0; pc_next = 32'h10;
    tick();
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL dir_pc_resume: got %h want 10", pc_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      CNTRL_write_en_addr_Rd = ($urandom_range(0, 3) != 0);
      // Bias towards R15 so the write/PC priority is hit often.
      mux_addr_Rd_or_15 = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      mux_ALU_result_or_DMEM_data = $urandom;
      pc_next = $urandom;
      IR_addr_Rn = 4'($urandom_range(0, 15));
      IR_addr_Rs = ($urandom_range(0, 3) == 0) ? IR_addr_Rn : 4'($urandom_range(0, 15));
      IR_addr_Rm = ($urandom_range(0, 3) == 0) ? mux_addr_Rd_or_15 : 4'($urandom_range(0, 15));
      #1;
      // Before the edge: pending write must not be visible yet.
      checks++; if (Rd !== mdl[mux_addr_Rd_or_15]) begin
        errors++; $display("FAIL rnd_pre_rd: n=%0d addr=%0d got %h want %h", n, mux_addr_Rd_or_15, Rd, mdl[mux_addr_Rd_or_15]);
      end
      tick();
      checks++; if (Rn !== mdl[IR_addr_Rn]) begin
        errors++; $display("FAIL rnd_rn: n=%0d addr=%0d got %h want %h", n, IR_addr_Rn, Rn, mdl[IR_addr_Rn]);
      end
      checks++; if (Rs !== mdl[IR_addr_Rs]) begin
        errors++; $display("FAIL rnd_rs: n=%0d addr=%0d got %h want %h", n, IR_addr_Rs, Rs, mdl[IR_addr_Rs]);
      end
      checks++; if (Rm !== mdl[IR_addr_Rm]) begin
        errors++; $display("FAIL rnd_rm: n=%0d addr=%0d got %h want %h", n, IR_addr_Rm, Rm, mdl[IR_addr_Rm]);
      end
      checks++; if (Rd !== mdl[mux_addr_Rd_or_15]) begin
        errors++; $display("FAIL rnd_rd: n=%0d addr=%0d got %h want %h", n, mux_addr_Rd_or_15, Rd, mdl[mux_addr_Rd_or_15]);
      end
      checks++; if (pc_out !== mdl[15]) begin
        errors++; $display("FAIL rnd_pc: n=%0d got %h want %h", n, pc_out, mdl[15]);
      end
    end
  endtask

  task automatic test_async_reset();
    // Load R0..R2 with non-zero values.
    CNTRL_write_en_addr_Rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mux_addr_Rd_or_15 = 4'(i);
      mux_ALU_result_or_DMEM_data = 32'hA000_0000 | 32'(i + 1);
      pc_next = 32'h200 + 32'(4 * i);
      tick();
    end
    CNTRL_write_en_addr_Rd = 1'b0;
    IR_addr_Rn = 4'd0; IR_addr_Rs = 4'd1; IR_addr_Rm = 4'd2; mux_addr_Rd_or_15 = 4'd2;
    #1;
    checks++; if ({Rn, Rs, Rm} !== {32'hA000_0001, 32'hA000_0002, 32'hA000_0003}) begin
      errors++; $display("FAIL arst_preload: got %h %h %h", Rn, Rs, Rm);
    end
    // Assert mid-cycle; clears before the next edge.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
    #1;
    checks++; if ({Rn, Rs, Rm, Rd, pc_out} !== 160'd0) begin
      errors++; $display("FAIL arst_clear: got %h %h %h %h %h want all 0", Rn, Rs, Rm, Rd, pc_out);
    end
    // Release mid-cycle: nothing changes until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    pc_next = 32'h0000_0044;
    #1;
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL arst_release_hold: got %h want 0", pc_out); end
    tick();
    checks++; if (pc_out !== 32'h44) begin errors++; $display("FAIL arst_first_edge_pc: got %h want 44", pc_out); end
    checks++; if (Rm !== 32'd0) begin errors++; $display("FAIL arst_r2_cleared: got %h want 0", Rm); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_16x32
